// File: rtl/ss_result_stat.sv
// Outcome statistics for the ss2bit comparator: windowed saturating counters, error flag, done pulse.
// Define SS_STREAK_EN to add max_streak, the longest run of consecutive A=B samples in the window.
module ss_result_stat #(
    parameter int unsigned CW    = 8,
    parameter int unsigned NSAMP = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          in_valid,
    input  logic          lon,
    input  logic          bang,
    input  logic          be,
    output logic [CW-1:0] cnt_lon,
    output logic [CW-1:0] cnt_bang,
    output logic [CW-1:0] cnt_be,
    output logic [CW-1:0] cnt_samp,
    output logic [1:0]    last_code,
    output logic          err,
    output logic          busy,
    output logic          done
`ifdef SS_STREAK_EN
    ,
    output logic [CW-1:0] max_streak
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [CW-1:0] CntMax  = '1;
    localparam logic [CW-1:0] LastIdx = CW'(NSAMP - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] lon_q, lon_d, bang_q, bang_d, be_q, be_d, samp_q, samp_d;
    logic [1:0]    code_q, code_d;
    logic          err_q, err_d;
    logic [1:0]    nhigh;
    logic          accept;
`ifdef SS_STREAK_EN
    logic [CW-1:0] cur_q, cur_d, best_q, best_d;
`endif

    function automatic logic [CW-1:0] sat_inc(logic [CW-1:0] v);
        return (v == CntMax) ? v : v + 1'b1;
    endfunction

    assign nhigh  = {1'b0, lon} + {1'b0, bang} + {1'b0, be};
    // All-zero samples mean the comparator is disabled; they are not accepted.
    assign accept = in_valid && (nhigh != 2'd0);

    always_comb begin
        state_d = state_q;
        lon_d   = lon_q;
        bang_d  = bang_q;
        be_d    = be_q;
        samp_d  = samp_q;
        code_d  = code_q;
        err_d   = err_q;
`ifdef SS_STREAK_EN
        cur_d   = cur_q;
        best_d  = best_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    lon_d   = '0;
                    bang_d  = '0;
                    be_d    = '0;
                    samp_d  = '0;
                    code_d  = 2'b00;
                    err_d   = 1'b0;
`ifdef SS_STREAK_EN
                    cur_d   = '0;
                    best_d  = '0;
`endif
                end
            end
            StRun: begin
                if (accept) begin
                    samp_d = samp_q + 1'b1;
                    if (nhigh == 2'd1) begin
                        if (lon) begin
                            lon_d  = sat_inc(lon_q);
                            code_d = 2'b01;
                        end else if (bang) begin
                            bang_d = sat_inc(bang_q);
                            code_d = 2'b10;
                        end else begin
                            be_d   = sat_inc(be_q);
                            code_d = 2'b11;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
`ifdef SS_STREAK_EN
                    if (nhigh == 2'd1 && bang) begin
                        cur_d = sat_inc(cur_q);
                        if (cur_d > best_q) best_d = cur_d;
                    end else begin
                        cur_d = '0;
                    end
`endif
                end
                if (stop || (accept && samp_q == LastIdx)) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            lon_q   <= '0;
            bang_q  <= '0;
            be_q    <= '0;
            samp_q  <= '0;
            code_q  <= 2'b00;
            err_q   <= 1'b0;
`ifdef SS_STREAK_EN
            cur_q   <= '0;
            best_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            lon_q   <= lon_d;
            bang_q  <= bang_d;
            be_q    <= be_d;
            samp_q  <= samp_d;
            code_q  <= code_d;
            err_q   <= err_d;
`ifdef SS_STREAK_EN
            cur_q   <= cur_d;
            best_q  <= best_d;
`endif
        end
    end

    assign cnt_lon   = lon_q;
    assign cnt_bang  = bang_q;
    assign cnt_be    = be_q;
    assign cnt_samp  = samp_q;
    assign last_code = code_q;
    assign err       = err_q;
    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
`ifdef SS_STREAK_EN
    assign max_streak = best_q;
`endif

endmodule

// File: tb/tb_ss_result_stat.sv
// Randomized plus directed bench for ss_result_stat; two instances (CW=8/NSAMP=4, CW=2/NSAMP=3)
// share stimulus and are compared every cycle against a window-level behavioural model.
module tb_ss_result_stat;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, stop = 1'b0, in_valid = 1'b0, lon = 1'b0, bang = 1'b0, be = 1'b0;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] a_lon, a_bang, a_be, a_samp;
    logic [1:0] a_code;
    logic       a_err, a_busy, a_done;
    logic [1:0] b_lon, b_bang, b_be, b_samp;
    logic [1:0] b_code;
    logic       b_err, b_busy, b_done;
`ifdef SS_STREAK_EN
    logic [7:0] a_streak;
    logic [1:0] b_streak;
`endif

    ss_result_stat #(.CW(8), .NSAMP(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
        .lon(lon), .bang(bang), .be(be),
        .cnt_lon(a_lon), .cnt_bang(a_bang), .cnt_be(a_be), .cnt_samp(a_samp),
        .last_code(a_code), .err(a_err), .busy(a_busy), .done(a_done)
`ifdef SS_STREAK_EN
        , .max_streak(a_streak)
`endif
    );

    ss_result_stat #(.CW(2), .NSAMP(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
        .lon(lon), .bang(bang), .be(be),
        .cnt_lon(b_lon), .cnt_bang(b_bang), .cnt_be(b_be), .cnt_samp(b_samp),
        .last_code(b_code), .err(b_err), .busy(b_busy), .done(b_done)
`ifdef SS_STREAK_EN
        , .max_streak(b_streak)
`endif
    );

    // phase: 0 idle, 1 window open, 2 window just closed
    typedef struct {
        int phase;
        int nl, nb, ne, ns;
        int last;
        int err;
        int cur, best;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mreset();
        mdl_t m;
        m.phase = 0; m.nl = 0; m.nb = 0; m.ne = 0; m.ns = 0;
        m.last = 0; m.err = 0; m.cur = 0; m.best = 0;
        return m;
    endfunction

    function automatic int smin(int x, int y);
        return (x < y) ? x : y;
    endfunction

    function automatic mdl_t step(mdl_t m, bit st, bit sp, bit v, bit l, bit b, bit e,
                                  int nsamp, int maxv);
        mdl_t n = m;
        int ones = int'(l) + int'(b) + int'(e);
        bit acc = v && (ones > 0);
        if (m.phase == 0) begin
            if (st) begin
                n = mreset();
                n.phase = 1;
            end
        end else if (m.phase == 1) begin
            if (acc) begin
                n.ns = m.ns + 1;
                if (ones == 1) begin
                    if (l) begin n.nl = smin(m.nl + 1, maxv); n.last = 1; end
                    if (b) begin n.nb = smin(m.nb + 1, maxv); n.last = 2; end
                    if (e) begin n.ne = smin(m.ne + 1, maxv); n.last = 3; end
                end else begin
                    n.err = 1;
                end
                if (ones == 1 && b) begin
                    n.cur = smin(m.cur + 1, maxv);
                    if (n.cur > n.best) n.best = n.cur;
                end else begin
                    n.cur = 0;
                end
            end
            if (sp || (acc && n.ns == nsamp)) n.phase = 2;
        end else begin
            n.phase = 0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= mreset();
            mb <= mreset();
        end else begin
            ma <= step(ma, start, stop, in_valid, lon, bang, be, 4, 255);
            mb <= step(mb, start, stop, in_valid, lon, bang, be, 3, 3);
        end
    end

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("A.cnt_lon", int'(a_lon), ma.nl);
        cmp("A.cnt_bang", int'(a_bang), ma.nb);
        cmp("A.cnt_be", int'(a_be), ma.ne);
        cmp("A.cnt_samp", int'(a_samp), ma.ns);
        cmp("A.last_code", int'(a_code), ma.last);
        cmp("A.err", int'(a_err), ma.err);
        cmp("A.busy", int'(a_busy), int'(ma.phase == 1));
        cmp("A.done", int'(a_done), int'(ma.phase == 2));
        cmp("B.cnt_lon", int'(b_lon), mb.nl);
        cmp("B.cnt_bang", int'(b_bang), mb.nb);
        cmp("B.cnt_be", int'(b_be), mb.ne);
        cmp("B.cnt_samp", int'(b_samp), mb.ns);
        cmp("B.last_code", int'(b_code), mb.last);
        cmp("B.err", int'(b_err), mb.err);
        cmp("B.busy", int'(b_busy), int'(mb.phase == 1));
        cmp("B.done", int'(b_done), int'(mb.phase == 2));
`ifdef SS_STREAK_EN
        cmp("A.max_streak", int'(a_streak), ma.best);
        cmp("B.max_streak", int'(b_streak), mb.best);
`endif
    end

    task automatic cyc(input bit st, input bit sp, input bit v, input bit l, input bit b,
                       input bit e);
        @(negedge clk);
        #2;
        start = st; stop = sp; in_valid = v; lon = l; bang = b; be = e;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        idle();
        cmp("reset.cnt_samp", int'(a_samp), 0);
        cmp("reset.busy", int'(a_busy), 0);

        // 1: lon,bang,be,bang fills the 4-sample window
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 1);
        cyc(0, 0, 1, 0, 1, 0);
        idle();
        cmp("t1.cnt_lon", int'(a_lon), 1);
        cmp("t1.cnt_bang", int'(a_bang), 2);
        cmp("t1.cnt_be", int'(a_be), 1);
        cmp("t1.cnt_samp", int'(a_samp), 4);
        cmp("t1.last_code", int'(a_code), 2);
        cmp("t1.done", int'(a_done), 1);
        cmp("t1.busy", int'(a_busy), 0);
        idle();

        // 2: only all-zero samples, then stop
        cyc(1, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        idle();
        cmp("t2.done", int'(a_done), 1);
        cmp("t2.cnt_samp", int'(a_samp), 0);
        cmp("t2.last_code", int'(a_code), 0);
        cmp("t2.err", int'(a_err), 0);
        idle();

        // 3: illegal code, legal be, stop; restart clears
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 1, 0);
        cyc(0, 0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0);
        idle();
        cmp("t3.err", int'(a_err), 1);
        cmp("t3.cnt_samp", int'(a_samp), 2);
        cmp("t3.cnt_be", int'(a_be), 1);
        cmp("t3.last_code", int'(a_code), 3);
        cyc(1, 0, 0, 0, 0, 0);
        idle();
        cmp("t3.restart_err", int'(a_err), 0);
        cmp("t3.restart_samp", int'(a_samp), 0);
        cyc(0, 1, 0, 0, 0, 0);
        idle();
        idle();

        // 4: narrow instance fills at 3; then stop coinciding with a sample
        cyc(1, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 1, 1, 0, 0);
        idle();
        cmp("t4.b_cnt_lon", int'(b_lon), 3);
        cmp("t4.b_done", int'(b_done), 1);
        cyc(0, 1, 0, 0, 0, 0);
        idle();
        idle();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 0, 0);
        idle();
        cmp("t4.b_cnt_lon2", int'(b_lon), 2);
        cmp("t4.a_done", int'(a_done), 1);
        cmp("t4.a_cnt_samp", int'(a_samp), 2);
        idle();

        // start and stop together in idle: window opens
        cyc(1, 1, 0, 0, 0, 0);
        idle();
        cmp("ss.busy", int'(a_busy), 1);
        cyc(0, 1, 0, 0, 0, 0);
        idle();
        idle();

        // 5: asynchronous reset mid-window, then samples without start
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 1, 0);
        idle();
        cmp("t5.pre_samp", int'(a_samp), 2);
        #1 rst_n = 1'b0;
        #1;
        cmp("t5.async_samp", int'(a_samp), 0);
        cmp("t5.async_bang", int'(a_bang), 0);
        cmp("t5.async_busy", int'(a_busy), 0);
        cmp("t5.async_code", int'(a_code), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) cyc(0, 0, 1, 1, 0, 0);
        idle();
        cmp("t5.nostart_samp", int'(a_samp), 0);
        cmp("t5.nostart_lon", int'(a_lon), 0);

        // 6: bang,bang,(zero),bang,lon,bang -> longest bang run 3 (A: NSAMP 4 stops early)
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 1, 0);
        idle();
`ifdef SS_STREAK_EN
        cmp("t6.max_streak", int'(a_streak), 3);
`endif
        cmp("t6.cnt_bang", int'(a_bang), 3);
        idle();
        idle();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit [2:0] code = 3'($urandom_range(7, 0));
            cyc(($urandom_range(9, 0) == 0), ($urandom_range(14, 0) == 0),
                ($urandom_range(3, 0) != 0), code[2], code[1], code[0]);
        end
        idle();
        idle();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ss_result_stat.md
Name: ss_result_stat

Overview:
- Downstream statistics stage for the ss2bit magnitude comparator.
- Samples its lon/bang/be outputs on a valid strobe during a measurement window.
- Counts A>B, A=B and A<B outcomes in saturating counters, flags illegal result codes and reports completion.
- Sits between the comparator and the bench/top-level readout logic.

Parameters:
- CW, 8, width of each outcome counter and of the sample counter
- NSAMP, 16, number of accepted samples that ends a window (1 .. 2^CW-1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; opens a new measurement window
- stop  input  1  one-cycle pulse; closes the window early
- in_valid  input  1  lon/bang/be are valid this cycle
- lon  input  1  comparator A>B
- bang  input  1  comparator A=B
- be  input  1  comparator A<B
- cnt_lon  output  CW  accepted A>B samples
- cnt_bang  output  CW  accepted A=B samples
- cnt_be  output  CW  accepted A<B samples
- cnt_samp  output  CW  accepted samples in window
- last_code  output  2  last accepted code: 01 lon, 10 bang, 11 be, 00 none
- err  output  1  sticky: illegal code seen in window
- busy  output  1  window open
- done  output  1  one-cycle pulse at window close

Behaviour:
- Reset (rst_n low, asynchronous): all counters 0, last_code 00, err 0, busy 0, done 0, FSM = IDLE.
- FSM states and transitions:
  - IDLE: start -> RUN. On entry to RUN, clear all counters, last_code and err in the same edge that sets busy.
  - RUN: busy=1.
    - stop -> DONE.
    - Accepting the NSAMP-th sample -> DONE.
    - start while in RUN is ignored.
  - DONE: one cycle; done=1, busy=0; then -> IDLE.
  - Counters, err and last_code hold their values in IDLE until the next start.
- Sample classification (RUN and in_valid), registered, 1-cycle latency to outputs:
  - Exactly one of lon/bang/be high (legal): increment that counter and cnt_samp; update last_code.
  - All three low (comparator disabled, E=0): sample ignored, no counter change.
  - Two or more high (illegal): err<=1, cnt_samp increments, no outcome counter changes, last_code unchanged.
- Saturation: outcome counters stop at 2^CW-1 and never wrap. cnt_samp never exceeds NSAMP.
- Simultaneous events:
  - stop and in_valid in the same cycle: the sample is accepted, then the FSM goes to DONE.
  - stop and the NSAMP-th sample in the same cycle: a single DONE, a single done pulse.
  - start and stop in the same IDLE cycle: start wins; the window opens and stop is ignored.
- in_valid outside RUN is ignored.
- Reset mid-window aborts immediately: no done pulse, all outputs return to reset values.

Optional Feature:
- Macro: SS_STREAK_EN.
- Defined:
  - Adds output max_streak (CW bits): the longest run of consecutive accepted legal bang samples in the current window.
  - The run is broken by any accepted non-bang sample (legal or illegal); ignored all-zero samples do not break it.
  - Saturating; cleared on window start and on reset.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. Reset, then NSAMP=4 with samples lon,bang,be,bang -> cnt_lon=1, cnt_bang=2, cnt_be=1, cnt_samp=4, last_code=10, done pulses one cycle after the 4th sample, busy=0.
2. start, 3 samples with all inputs 0, then stop -> all counters 0, err=0, last_code=00, done=1 once.
3. start, sample lon=1 bang=1, then a legal be sample, then stop -> err=1, cnt_samp=2, cnt_be=1, last_code=11. After a new start -> err=0 and counters 0.
4. CW=2, NSAMP=3, three lon samples -> cnt_lon=3. Repeat with CW=2, NSAMP=3, stop after 2 -> cnt_lon=2, no wrap.
5. rst_n low during RUN after 2 samples -> outputs 0 asynchronously, no done pulse. After release, in_valid samples without start -> no counts.
6. With SS_STREAK_EN defined: bang,bang,(all zero),bang,lon,bang -> max_streak=3.
